// File: rtl/pan_pkg.sv
// Shared types and constants for the PAN capture front end and the Luhn validator.
package pan_pkg;

  localparam int          PAN_W      = 76;
  localparam int          MAX_DIGITS = 19;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic {S_COLLECT, S_DONE} cap_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/pan_capture_if.sv
// Digit handshake and captured-PAN bundle between the keypad/UART decoder side and pan_capture.
interface pan_capture_if;

  logic                       digit_valid;
  pan_pkg::bcd_t              digit_in;
  logic                       digit_ready;
  logic                       backspace;
  logic                       clear;
  logic [pan_pkg::PAN_W-1:0]  pan_bcd;
  logic                       pan_ready;
  logic [4:0]                 digit_count;
  logic                       err_bad_digit;
  logic                       timeout;

  modport master (
    output digit_valid, digit_in, backspace, clear,
    input  digit_ready, pan_bcd, pan_ready, digit_count, err_bad_digit, timeout
  );

  modport slave (
    input  digit_valid, digit_in, backspace, clear,
    output digit_ready, pan_bcd, pan_ready, digit_count, err_bad_digit, timeout
  );

endinterface

// File: rtl/pan_idle_timer.sv
// Inactivity counter: raises expire_pulse when run has been held TIMEOUT_CYCLES-1 cycles without a kick.
module pan_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire_pulse
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expire_pulse = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_q;

    // a kick from the same cycle outranks expiry, so activity always wins the race
    assign expire_pulse = run && !kick && (idle_q == LAST);

    // count idle cycles while running; any activity, a stop or an expiry restarts from zero
    always_ff @(posedge clk) begin
      if (rst) begin
        idle_q <= '0;
      end else if (kick || !run || expire_pulse) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pan_capture.sv
// Serial-to-parallel PAN assembler: one BCD digit per handshake, leftmost digit at nibble 0.
module pan_capture
  import pan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  pan_capture_if.slave  bus
);

  localparam logic [4:0] FULL_COUNT = 5'(NUM_DIGITS);
  localparam logic [PAN_W-1:0] PAN_MASK =
    (NUM_DIGITS >= MAX_DIGITS) ? {PAN_W{1'b1}}
                               : ((PAN_W'(1) << (4 * NUM_DIGITS)) - PAN_W'(1));

  cap_state_t        state_q, state_d;
  logic [PAN_W-1:0]  pan_q, pan_d;
  logic [4:0]        count_q, count_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              accept;
  logic              run;
  logic              kick;
  logic              expire;
  logic [6:0]        wr_base;
  logic [6:0]        bs_base;

  assign bus.digit_ready = (state_q == S_COLLECT) && !bus.clear && !bus.backspace;
  assign accept          = bus.digit_valid && bus.digit_ready;
  assign run             = (state_q == S_COLLECT) && (count_q != 5'd0);
  assign kick            = bus.clear || bus.backspace || accept;
  assign wr_base         = {count_q, 2'b00};
  assign bs_base         = {count_q - 5'd1, 2'b00};

  pan_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .kick         (kick),
    .expire_pulse (expire)
  );

  // next-state decode in priority order: clear, backspace, digit accept, timeout
  always_comb begin
    state_d = state_q;
    pan_d   = pan_q;
    count_d = count_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    if (bus.clear) begin
      pan_d   = '0;
      count_d = 5'd0;
      state_d = S_COLLECT;
    end else if (bus.backspace) begin
      if (count_q != 5'd0) begin
        pan_d[bs_base +: 4] = 4'd0;
        count_d             = count_q - 5'd1;
        state_d             = S_COLLECT;
      end
    end else if (accept) begin
      if (bus.digit_in <= BCD_MAX) begin
        pan_d[wr_base +: 4] = bus.digit_in;
        count_d             = count_q + 5'd1;
        if (count_q + 5'd1 == FULL_COUNT) begin
          state_d = S_DONE;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (expire) begin
      pan_d   = '0;
      count_d = 5'd0;
      state_d = S_COLLECT;
      tmo_d   = 1'b1;
    end
  end

  // state, digit register and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
      pan_q   <= '0;
      count_q <= 5'd0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pan_q   <= pan_d;
      count_q <= count_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.pan_bcd       = pan_q & PAN_MASK;
  assign bus.pan_ready     = (state_q == S_DONE);
  assign bus.digit_count   = count_q;
  assign bus.err_bad_digit = err_q;
  assign bus.timeout       = tmo_q;

endmodule

// File: tb/tb_pan_capture.sv
// Directed bench for pan_capture with a behavioural model feeding a scoreboard queue.
module tb_pan_capture;

  localparam int ND  = 16;
  localparam int TMO = 8;

  typedef struct packed {
    logic [75:0] pan;
    logic [4:0]  count;
    logic        ready;
    logic        err;
    logic        tmo;
  } exp_t;

  logic clk;
  logic rst;

  pan_capture_if bus ();

  pan_capture #(
    .NUM_DIGITS     (ND),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  exp_t exp_q[$];

  logic [75:0] m_pan;
  int          m_count;
  logic        m_done;
  int          m_idle;

  // free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [75:0] obs, input logic [75:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_pan   = '0;
    m_count = 0;
    m_done  = 1'b0;
    m_idle  = 0;
  endtask

  task automatic modelStep(input logic v, input logic [3:0] d, input logic bs, input logic clr);
    exp_t e;
    logic rdy;
    rdy   = !m_done && !clr && !bs;
    e.err = 1'b0;
    e.tmo = 1'b0;
    if (clr) begin
      modelReset();
    end else if (bs) begin
      if (m_count != 0) begin
        m_pan[4*(m_count-1) +: 4] = 4'd0;
        m_count--;
        m_done = 1'b0;
      end
      m_idle = 0;
    end else if (v && rdy) begin
      m_idle = 0;
      if (d <= 4'd9) begin
        m_pan[4*m_count +: 4] = d;
        m_count++;
        if (m_count == ND) m_done = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end else if (!m_done && m_count != 0) begin
      if (m_idle == TMO - 1) begin
        modelReset();
        e.tmo = 1'b1;
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
    e.pan   = m_pan;
    e.count = 5'(m_count);
    e.ready = m_done;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    checkField({tag, "/pan"},   bus.pan_bcd,       e.pan);
    checkField({tag, "/count"}, bus.digit_count,   e.count);
    checkField({tag, "/ready"}, bus.pan_ready,     e.ready);
    checkField({tag, "/err"},   bus.err_bad_digit, e.err);
    checkField({tag, "/tmo"},   bus.timeout,       e.tmo);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic bs,
                               input logic clr, input string tag);
    logic rdy;
    bus.digit_valid = v;
    bus.digit_in    = d;
    bus.backspace   = bs;
    bus.clear       = clr;
    #1;
    rdy = !m_done && !clr && !bs;
    checkField({tag, "/digit_ready"}, bus.digit_ready, rdy);
    modelStep(v, d, bs, clr);
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.backspace   = 1'b0;
    bus.clear       = 1'b0;
    checkOutput(tag);
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    exp_q.delete();
    checkField({tag, "/pan"},   bus.pan_bcd,       76'd0);
    checkField({tag, "/count"}, bus.digit_count,   76'd0);
    checkField({tag, "/ready"}, bus.pan_ready,     76'd0);
    checkField({tag, "/err"},   bus.err_bad_digit, 76'd0);
    checkField({tag, "/tmo"},   bus.timeout,       76'd0);
  endtask

  task automatic feedDigit(input logic [3:0] d, input string tag);
    applyStimulus(1'b1, d, 1'b0, 1'b0, tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, tag);
  endtask

  // linear directed sequence covering the capture, edit, collision, timeout and reset cases
  initial begin
    logic any_tmo;
    rst             = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.backspace   = 1'b0;
    bus.clear       = 1'b0;
    modelReset();

    applyReset("reset");

    $display("[TB] full capture");
    feedDigit(4'd4, "t1/d0");
    for (int i = 1; i < ND; i++) feedDigit(4'd1, $sformatf("t1/d%0d", i));
    checkField("t1/pan_const",   bus.pan_bcd,     76'h000_1111111111111114);
    checkField("t1/ready_const", bus.pan_ready,   76'd1);
    checkField("t1/count_const", bus.digit_count, 76'd16);
    feedDigit(4'd3, "t1/refused");

    $display("[TB] backspace");
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "t3/bs_done");
    checkField("t3/ready_drop", bus.pan_ready,       76'd0);
    checkField("t3/count15",    bus.digit_count,     76'd15);
    checkField("t3/nib15_zero", bus.pan_bcd[63:60],  76'd0);
    feedDigit(4'd7, "t3/refill");
    checkField("t3/ready_again", bus.pan_ready,      76'd1);
    checkField("t3/nib15_seven", bus.pan_bcd[63:60], 76'd7);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, "t3/clear");
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "t3/bs_empty");
    checkField("t3/empty_count", bus.digit_count, 76'd0);

    $display("[TB] bad digit");
    feedDigit(4'd5, "t2/d5");
    feedDigit(4'hB, "t2/dB");
    checkField("t2/err_pulse", bus.err_bad_digit, 76'd1);
    feedDigit(4'd3, "t2/d3");
    checkField("t2/err_clear", bus.err_bad_digit, 76'd0);
    checkField("t2/count2",    bus.digit_count,   76'd2);
    checkField("t2/low_byte",  bus.pan_bcd[7:0],  76'h35);

    $display("[TB] collisions");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, "t4/clear0");
    feedDigit(4'd1, "t4/d1");
    feedDigit(4'd2, "t4/d2");
    feedDigit(4'd3, "t4/d3");
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, "t4/bs_vs_digit");
    checkField("t4/count2", bus.digit_count,  76'd2);
    checkField("t4/no9",    bus.pan_bcd[11:0], 76'h021);
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, "t4/clear_wins");
    checkField("t4/count0", bus.digit_count, 76'd0);

    $display("[TB] timeout");
    feedDigit(4'd8, "t5/d8");
    feedDigit(4'd6, "t5/d6");
    for (int i = 0; i < TMO; i++) begin
      idleCycle($sformatf("t5/idle%0d", i));
      checkField($sformatf("t5/tmo_at%0d", i), bus.timeout, 76'(i == TMO - 1));
    end
    checkField("t5/pan_zero", bus.pan_bcd,     76'd0);
    checkField("t5/count0",   bus.digit_count, 76'd0);
    for (int i = 0; i < ND; i++) feedDigit(4'(i % 10), $sformatf("t5/full%0d", i));
    any_tmo = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idleCycle($sformatf("t5/hold%0d", i));
      any_tmo = any_tmo | bus.timeout;
    end
    checkField("t5/held_ready", bus.pan_ready, 76'd1);
    checkField("t5/never_tmo",  any_tmo,       76'd0);

    $display("[TB] reset mid-entry");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, "t6/clear");
    for (int i = 0; i < 10; i++) feedDigit(4'd9, $sformatf("t6/pre%0d", i));
    applyReset("t6/reset");
    for (int i = 0; i < ND; i++) feedDigit(4'd2, $sformatf("t6/fresh%0d", i));
    checkField("t6/ready", bus.pan_ready, 76'd1);
    checkField("t6/pan",   bus.pan_bcd,   76'h000_2222222222222222);

    checkField("end/scoreboard_drained", 76'(exp_q.size()), 76'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pan_capture.md
Name: pan_capture

Overview:
- Serial-to-parallel front end placed directly upstream of the Luhn validator.
- Accepts one BCD digit per handshake from the keypad/UART decoder and assembles a 16-digit PAN, leftmost digit first.
- Drives pan_bcd and pan_ready straight into the validator.
- Supports backspace, clear, rejection of non-BCD digits, and an inactivity timeout that discards partial entries.

Parameters:
- NUM_DIGITS, 16, digits per PAN. Legal range 13..19.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before a partial entry is discarded. 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on the rising edge
- rst  input  1  synchronous, active-high reset
- digit_valid  input  1  digit_in carries a digit this cycle
- digit_in  input  4  BCD digit, legal values 0..9
- digit_ready  output  1  block can accept a digit this cycle
- backspace  input  1  remove the last captured digit (single-cycle pulse)
- clear  input  1  discard the whole entry (single-cycle pulse)
- pan_bcd  output  76  captured PAN. Digit k (k=0 is leftmost) sits at [4k+3:4k]. Unused high nibbles are 0.
- pan_ready  output  1  NUM_DIGITS digits captured and pan_bcd is stable
- digit_count  output  5  number of digits currently held
- err_bad_digit  output  1  one-cycle pulse: a non-BCD digit was offered and dropped
- timeout  output  1  one-cycle pulse: partial entry discarded for inactivity

Behaviour:
- Reset (rst=1 at a clock edge, also mid-entry): state=S_COLLECT, pan_bcd=0, digit_count=0, pan_ready=0, err_bad_digit=0, timeout=0, idle counter=0.
- States:
  - S_COLLECT: accepting digits.
  - S_DONE: full PAN held, all digits refused.
- digit_ready = (state==S_COLLECT) && !clear && !backspace. It is combinational and does not depend on digit_valid.
- Accept: digit_valid && digit_ready at an edge.
  - digit_in <= 9: write the nibble at index digit_count and increment digit_count. Both are visible the next cycle.
  - digit_in > 9: handshake completes, but the nibble is not written and the count is unchanged. err_bad_digit=1 for exactly the next cycle.
- Completion: the accept that makes digit_count==NUM_DIGITS also moves the state to S_DONE. pan_ready goes high in the same next cycle, i.e. one cycle after the final handshake edge.
- pan_ready is registered and equals (state==S_DONE). pan_bcd never changes while pan_ready=1.
- Priority when signals coincide in one cycle: rst > clear > backspace > digit accept > timeout.
- clear, from either state: pan_bcd=0, digit_count=0, state=S_COLLECT, idle counter=0. With a count of 0 it has no visible effect.
- backspace:
  - digit_count==0: no-op.
  - Otherwise: zero nibble [digit_count-1], decrement the count, state=S_COLLECT. From S_DONE this drops pan_ready on the next cycle, leaving NUM_DIGITS-1 digits.
- Idle counter:
  - Runs only in S_COLLECT with digit_count>0.
  - Resets to 0 on any accept (including a bad digit), backspace or clear.
  - On reaching TIMEOUT_CYCLES-1 it acts as clear, and timeout pulses high for exactly one cycle.
  - Held at 0 in S_DONE; a completed PAN never times out.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Width rules:
  - digit_count is 5 bits and saturates logically at NUM_DIGITS; it is never incremented in S_DONE.
  - pan_bcd[75:4*NUM_DIGITS] is tied to 0.
- Nibble writes use an indexed part-select on a 76-bit register. There is no shifting, so backspace is O(1).

Decomposition:
- Package pan_pkg holds:
  - PAN_W=76, MAX_DIGITS=19, BCD_MAX=4'd9
  - typedef enum logic {S_COLLECT, S_DONE} cap_state_t
  - typedef logic [3:0] bcd_t
- This package is shared with the validator.
- One sub-module, pan_idle_timer, contains the parameterised counter. Its interface: inputs run and kick, output expire_pulse.
- The digit register and FSM stay in pan_capture.

Test Plan:
1. Full capture:
   - Stimulus: after reset, feed 4,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1 back-to-back.
   - Required: pan_bcd=76'h000_1111111111111114; pan_ready=1 one cycle after the 16th accept; digit_ready=0 afterwards; digit_count=16.
2. Bad digit:
   - Stimulus: feed 5, then 4'hB, then 3.
   - Required: err_bad_digit pulses once for the B; digit_count ends at 2; pan_bcd[7:0]=8'h35.
3. Backspace:
   - Stimulus: capture 16 digits, assert backspace in S_DONE.
   - Required: next cycle pan_ready=0, digit_count=15, pan_bcd[63:60]=0. Re-feeding digit 7 gives pan_ready=1 and [63:60]=7.
   - Also: backspace at count 0 changes nothing.
4. Collisions:
   - Stimulus: digit_valid=1 with digit 9, same cycle as backspace at count 3; separately, clear with backspace and digit_valid.
   - Required: first case, digit not accepted and count becomes 2. Second case, clear wins and count=0.
5. Timeout (TIMEOUT_CYCLES=8):
   - Stimulus: feed 2 digits, then idle.
   - Required: timeout pulses 8 cycles after the last accept; pan_bcd=0; count=0.
   - Also: a full PAN held idle for 100 cycles never times out.
6. Reset mid-entry:
   - Stimulus: rst=1 for one cycle after 10 digits.
   - Required: all outputs return to reset values the next cycle, and a fresh 16-digit entry completes normally.
